// File: rtl/cpu_controller.sv
// Multi-cycle CPU control unit: a Moore FSM that sequences fetch, decode, execute,
// memory access and write-back, driving datapath strobes and mux selects.
module cpu_controller #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] instr,
  input  logic             mem_rdy,
  input  logic             flag_z,
  output logic             pcen,
  output logic             irwrite,
  output logic             regwrite,
  output logic             memread,
  output logic             memwrite,
  output logic             wa_s,
  output logic             pc_s,
  output logic             alub_s,
  output logic [1:0]       wd_s,
  output logic [1:0]       alua_s,
  output logic [2:0]       alucont,
  output logic             signext_sign,
  output logic [3:0]       state,
  output logic             halted
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EXEC_R  = 4'd2,
    S_EXEC_I  = 4'd3,
    S_ALU_WB  = 4'd4,
    S_MOVI_WB = 4'd5,
    S_MEM_RD  = 4'd6,
    S_LOAD_WB = 4'd7,
    S_MEM_WR  = 4'd8,
    S_BRANCH  = 4'd9,
    S_JUMP    = 4'd10,
    S_HALT    = 4'd11
  } state_e;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_XOR  = 3'b011;
  localparam logic [2:0] ALU_PASS = 3'b100;
  localparam logic [2:0] ALU_SUB  = 3'b110;

  typedef struct packed {
    logic       pcen;
    logic       irwrite;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       wa_s;
    logic       pc_s;
    logic       alub_s;
    logic [1:0] wd_s;
    logic [1:0] alua_s;
    logic [2:0] alucont;
    logic       signext_sign;
    logic       halted;
  } ctrl_t;

  state_e     state_q;
  state_e     state_d;
  ctrl_t      ctrl_dec_s;
  ctrl_t      ctrl_s;
  logic [3:0] opcode_s;
  logic [3:0] ext_s;
  logic       unused_instr_s;

  assign opcode_s       = instr[WIDTH-1 -: 4];
  assign ext_s          = instr[7:4];
  assign unused_instr_s = ^{instr[WIDTH-5:8], instr[3:0]};

  // R-type function field to ALU operation; unknown functions fall back to ADD.
  function automatic logic [2:0] alu_sel(input logic [3:0] ext);
    logic [2:0] op;
    case (ext)
      4'b0101: op = ALU_ADD;
      4'b1001: op = ALU_SUB;
      4'b0001: op = ALU_AND;
      4'b0010: op = ALU_OR;
      4'b0011: op = ALU_XOR;
      4'b1101: op = ALU_PASS;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: begin
        if (mem_rdy) state_d = S_DECODE;
        else         state_d = S_FETCH;
      end
      S_DECODE: begin
        case (opcode_s)
          4'b0000: state_d = S_EXEC_R;
          4'b0101: state_d = S_EXEC_I;
          4'b1101: state_d = S_MOVI_WB;
          4'b1100: state_d = S_BRANCH;
          4'b1111: state_d = S_HALT;
          4'b0100: begin
            case (ext_s)
              4'b0000: state_d = S_MEM_RD;
              4'b0100: state_d = S_MEM_WR;
              4'b1100: state_d = S_JUMP;
              default: state_d = S_FETCH;
            endcase
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_EXEC_R:  state_d = S_ALU_WB;
      S_EXEC_I:  state_d = S_ALU_WB;
      S_MEM_RD: begin
        if (mem_rdy) state_d = S_LOAD_WB;
        else         state_d = S_MEM_RD;
      end
      S_MEM_WR: begin
        if (mem_rdy) state_d = S_FETCH;
        else         state_d = S_MEM_WR;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Output decode; reset forces every output low without waiting for a clock.
  always_comb begin
    ctrl_dec_s = {$bits(ctrl_t){1'b0}};
    case (state_q)
      S_FETCH: begin
        ctrl_dec_s.memread = 1'b1;
        ctrl_dec_s.alua_s  = 2'b01;
        ctrl_dec_s.alub_s  = 1'b1;
        ctrl_dec_s.alucont = ALU_ADD;
        ctrl_dec_s.pc_s    = 1'b1;
        ctrl_dec_s.irwrite = mem_rdy;
        ctrl_dec_s.pcen    = mem_rdy;
      end
      S_EXEC_R: begin
        ctrl_dec_s.alucont = alu_sel(ext_s);
      end
      S_EXEC_I: begin
        ctrl_dec_s.alua_s       = 2'b10;
        ctrl_dec_s.alucont      = ALU_ADD;
        ctrl_dec_s.signext_sign = 1'b1;
      end
      S_ALU_WB: begin
        ctrl_dec_s.regwrite = 1'b1;
        ctrl_dec_s.wd_s     = 2'b11;
        ctrl_dec_s.wa_s     = 1'b1;
      end
      S_MOVI_WB: begin
        ctrl_dec_s.regwrite = 1'b1;
        ctrl_dec_s.wa_s     = 1'b1;
      end
      S_MEM_RD: begin
        ctrl_dec_s.memread = 1'b1;
      end
      S_LOAD_WB: begin
        ctrl_dec_s.regwrite = 1'b1;
        ctrl_dec_s.wd_s     = 2'b10;
        ctrl_dec_s.wa_s     = 1'b1;
      end
      S_MEM_WR: begin
        ctrl_dec_s.memwrite = 1'b1;
      end
      S_BRANCH: begin
        ctrl_dec_s.alua_s       = 2'b10;
        ctrl_dec_s.alucont      = ALU_PASS;
        ctrl_dec_s.signext_sign = 1'b1;
        ctrl_dec_s.pc_s         = 1'b1;
        ctrl_dec_s.pcen         = flag_z;
      end
      S_JUMP: begin
        ctrl_dec_s.pcen = 1'b1;
      end
      S_HALT: begin
        ctrl_dec_s.halted = 1'b1;
      end
      default: begin
        ctrl_dec_s = {$bits(ctrl_t){1'b0}};
      end
    endcase
    if (!reset) begin
      ctrl_s = {$bits(ctrl_t){1'b0}};
    end else begin
      ctrl_s = ctrl_dec_s;
    end
  end

  assign pcen         = ctrl_s.pcen;
  assign irwrite      = ctrl_s.irwrite;
  assign regwrite     = ctrl_s.regwrite;
  assign memread      = ctrl_s.memread;
  assign memwrite     = ctrl_s.memwrite;
  assign wa_s         = ctrl_s.wa_s;
  assign pc_s         = ctrl_s.pc_s;
  assign alub_s       = ctrl_s.alub_s;
  assign wd_s         = ctrl_s.wd_s;
  assign alua_s       = ctrl_s.alua_s;
  assign alucont      = ctrl_s.alucont;
  assign signext_sign = ctrl_s.signext_sign;
  assign halted       = ctrl_s.halted;
  assign state        = state_q;

endmodule

// File: tb/tb_cpu_controller.sv
// Bench for cpu_controller: each instruction is expanded into a per-cycle plan of
// inputs and expected outputs, which one process drives and checks every cycle.
module tb_cpu_controller;

  typedef struct packed {
    logic [3:0] state;
    logic       halted;
    logic       pcen;
    logic       irwrite;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       wa_s;
    logic       pc_s;
    logic       alub_s;
    logic [1:0] wd_s;
    logic [1:0] alua_s;
    logic [2:0] alucont;
    logic       signext_sign;
  } obs_t;

  typedef struct {
    logic [15:0] instr;
    logic        rdy;
    logic        fz;
    obs_t        exp;
  } cyc_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] instr = 16'h0000;
  logic        mem_rdy = 1'b0;
  logic        flag_z = 1'b0;
  logic        pcen, irwrite, regwrite, memread, memwrite, wa_s, pc_s, alub_s;
  logic [1:0]  wd_s, alua_s;
  logic [2:0]  alucont;
  logic        signext_sign, halted;
  logic [3:0]  state;
  obs_t        dut_obs;

  int   checks = 0;
  int   passes = 0;
  int   rw_cnt, mw_cnt, mw_hs_cnt;
  bit   tog = 1'b0;
  cyc_t q[$];

  cpu_controller #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .instr(instr), .mem_rdy(mem_rdy), .flag_z(flag_z),
    .pcen(pcen), .irwrite(irwrite), .regwrite(regwrite), .memread(memread),
    .memwrite(memwrite), .wa_s(wa_s), .pc_s(pc_s), .alub_s(alub_s), .wd_s(wd_s),
    .alua_s(alua_s), .alucont(alucont), .signext_sign(signext_sign),
    .state(state), .halted(halted)
  );

  assign dut_obs = {state, halted, pcen, irwrite, regwrite, memread, memwrite,
                    wa_s, pc_s, alub_s, wd_s, alua_s, alucont, signext_sign};

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%h expected=%h", nm, act, exp);
  endtask

  function automatic logic [2:0] alu_of(input logic [3:0] ext);
    case (ext)
      4'h9:    return 3'b110;
      4'h1:    return 3'b000;
      4'h2:    return 3'b001;
      4'h3:    return 3'b011;
      4'hD:    return 3'b100;
      default: return 3'b010;
    endcase
  endfunction

  function automatic obs_t idle(input logic [3:0] st);
    obs_t o;
    o = '0;
    o.state = st;
    return o;
  endfunction

  task automatic push(input logic [15:0] ins, input logic rdy, input logic fz, input obs_t e);
    cyc_t c;
    c.instr = ins; c.rdy = rdy; c.fz = fz; c.exp = e;
    q.push_back(c);
  endtask

  // mem_rdy in states that ignore it alternates, to show it has no effect there.
  task automatic push_any(input logic [15:0] ins, input logic fz, input obs_t e);
    tog = ~tog;
    push(ins, tog, fz, e);
  endtask

  task automatic push_wb(input logic [15:0] ins, input logic fz, input logic [3:0] st,
                         input logic [1:0] wd);
    obs_t e;
    e = idle(st); e.regwrite = 1'b1; e.wd_s = wd; e.wa_s = 1'b1;
    push_any(ins, fz, e);
  endtask

  task automatic plan_prefix(input logic [15:0] ins, input logic fz, input int fw);
    obs_t e;
    for (int i = 0; i <= fw; i++) begin
      e = idle(4'd0);
      e.memread = 1'b1; e.alua_s = 2'b01; e.alub_s = 1'b1; e.alucont = 3'b010; e.pc_s = 1'b1;
      e.irwrite = (i == fw); e.pcen = (i == fw);
      push(ins, (i == fw), fz, e);
    end
    push_any(ins, fz, idle(4'd1));
  endtask

  // fw: FETCH wait cycles; mw: memory wait cycles, or HALT observation cycles.
  task automatic plan(input logic [15:0] ins, input logic fz, input int fw, input int mw);
    obs_t e;
    logic [3:0] op, ext;
    op = ins[15:12];
    ext = ins[7:4];
    plan_prefix(ins, fz, fw);
    if (op == 4'h0) begin
      e = idle(4'd2); e.alucont = alu_of(ext); push_any(ins, fz, e);
      push_wb(ins, fz, 4'd4, 2'b11);
    end else if (op == 4'h5) begin
      e = idle(4'd3); e.alua_s = 2'b10; e.alucont = 3'b010; e.signext_sign = 1'b1;
      push_any(ins, fz, e);
      push_wb(ins, fz, 4'd4, 2'b11);
    end else if (op == 4'hD) begin
      push_wb(ins, fz, 4'd5, 2'b00);
    end else if (op == 4'h4 && ext == 4'h0) begin
      for (int i = 0; i <= mw; i++) begin
        e = idle(4'd6); e.memread = 1'b1; push(ins, (i == mw), fz, e);
      end
      push_wb(ins, fz, 4'd7, 2'b10);
    end else if (op == 4'h4 && ext == 4'h4) begin
      for (int i = 0; i <= mw; i++) begin
        e = idle(4'd8); e.memwrite = 1'b1; push(ins, (i == mw), fz, e);
      end
    end else if (op == 4'h4 && ext == 4'hC) begin
      e = idle(4'd10); e.pcen = 1'b1; push_any(ins, fz, e);
    end else if (op == 4'hC) begin
      e = idle(4'd9); e.alua_s = 2'b10; e.alucont = 3'b100; e.signext_sign = 1'b1;
      e.pc_s = 1'b1; e.pcen = fz; push_any(ins, fz, e);
    end else if (op == 4'hF) begin
      e = idle(4'd11); e.halted = 1'b1;
      for (int i = 0; i < mw; i++) push_any(ins, fz, e);
    end
  endtask

  // The single compare process: drive each planned cycle and check every output.
  task automatic run_plan(input string tag);
    cyc_t c;
    int n = 0;
    rw_cnt = 0; mw_cnt = 0; mw_hs_cnt = 0;
    while (q.size() > 0) begin
      c = q.pop_front();
      @(negedge clk);
      reset = 1'b1; instr = c.instr; mem_rdy = c.rdy; flag_z = c.fz;
      #1;
      chk($sformatf("%s_c%0d", tag, n), {11'd0, dut_obs}, {11'd0, c.exp});
      if (regwrite) rw_cnt++;
      if (memwrite) mw_cnt++;
      if (memwrite && mem_rdy) mw_hs_cnt++;
      n++;
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      mem_rdy = i[0];
      #1;
      chk($sformatf("%s_rst%0d", tag, i), {11'd0, dut_obs}, 32'd0);
    end
  endtask

  initial begin
    do_reset("init");

    plan(16'h0152, 1'b0, 0, 0);
    chk("lat_add", q.size(), 32'd4);
    chk("add_exec_alu", {29'd0, q[2].exp.alucont}, 32'd2);
    run_plan("add");
    chk("add_rw_once", rw_cnt, 32'd1);

    plan(16'h5123, 1'b0, 1, 0);
    chk("lat_addi_w1", q.size(), 32'd5);
    run_plan("addi");

    plan(16'hD0FF, 1'b0, 0, 0);
    chk("lat_movi", q.size(), 32'd3);
    run_plan("movi");

    plan(16'h4203, 1'b0, 0, 3);
    chk("lat_load_w3", q.size(), 32'd7);
    chk("load_hold", {28'd0, q[5].exp.state}, 32'd6);
    chk("load_wd", {30'd0, q[6].exp.wd_s}, 32'd2);
    run_plan("load");

    plan(16'h4245, 1'b0, 0, 2);
    chk("lat_stor_w2", q.size(), 32'd5);
    run_plan("stor");
    chk("stor_mw_cycles", mw_cnt, 32'd3);
    chk("stor_mw_handshake", mw_hs_cnt, 32'd1);

    plan(16'hC0F0, 1'b1, 0, 0);
    chk("br_taken_pcen", {31'd0, q[2].exp.pcen}, 32'd1);
    run_plan("br_t");
    plan(16'hC0F0, 1'b0, 0, 0);
    chk("lat_branch", q.size(), 32'd3);
    run_plan("br_nt");

    plan(16'h40C0, 1'b0, 0, 0);
    chk("lat_jump", q.size(), 32'd3);
    run_plan("jump");

    plan(16'h0090, 1'b0, 0, 0);
    plan(16'h0010, 1'b0, 0, 0);
    plan(16'h0020, 1'b0, 0, 0);
    plan(16'h0030, 1'b0, 0, 0);
    plan(16'h00D0, 1'b0, 0, 0);
    plan(16'h0070, 1'b0, 0, 0);
    chk("sub_alu", {29'd0, q[2].exp.alucont}, 32'd6);
    run_plan("rtype");

    plan(16'h7000, 1'b0, 0, 0);
    plan(16'h4010, 1'b0, 0, 0);
    chk("lat_nop_pair", q.size(), 32'd4);
    run_plan("nop");
    chk("nop_no_rw", rw_cnt, 32'd0);
    chk("nop_no_mw", mw_cnt, 32'd0);

    // Reset asserted mid-cycle while a store waits on memory.
    plan_prefix(16'h4245, 1'b0, 0);
    begin
      obs_t e;
      e = idle(4'd8); e.memwrite = 1'b1;
      push(16'h4245, 1'b0, 1'b0, e);
    end
    run_plan("stor_wait");
    #2;
    reset = 1'b0;
    #1;
    chk("stor_rst_memwrite", {31'd0, memwrite}, 32'd0);
    chk("stor_rst_obs", {11'd0, dut_obs}, 32'd0);
    do_reset("stor");
    plan(16'h0152, 1'b0, 0, 0);
    run_plan("post_stor");

    plan(16'hF000, 1'b0, 0, 20);
    chk("halt_len", q.size(), 32'd22);
    run_plan("halt");
    do_reset("halt");
    plan(16'h0152, 1'b0, 2, 0);
    run_plan("post_halt");
    chk("post_halt_rw", rw_cnt, 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
